// File: rtl/y_signature_misr.sv
// y_signature_misr
//   Compacts a run of NUM_SAMPLES upstream result words into a SIG_W-bit
//   multiple-input signature (MISR). Each qualified sample of the wide y bus
//   is first folded down to SIG_W bits by XOR-ing its SIG_W-bit chunks
//   (zero-padded at the top, chunk 0 = y[SIG_W-1:0]), then shifted into the
//   signature register together with the polynomial feedback.
//
//   Optional feature macro: SIG_COMPARE_EN
//     defined   -> exp_sig port exists; match is a registered sig==exp_sig
//                  compare, high only in DONE
//     undefined -> no exp_sig port; match is tied low
//
//   Ports
//     clk      in   single clock, all state on rising edge
//     rst_n    in   asynchronous active-low reset
//     start    in   begin a new run (accepted in IDLE/DONE only)
//     y_valid  in   y holds a sample this cycle
//     y        in   [Y_W]   upstream result bus
//     exp_sig  in   [SIG_W] expected signature (SIG_COMPARE_EN only)
//     busy     out  high in RUN
//     done     out  high in DONE
//     sig      out  [SIG_W] signature register
//     count    out  [5]     samples absorbed in the current run
//     match    out  sig==exp_sig while in DONE
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | after reset, waiting for start; sig=SEED, count=0
//   RUN   | absorbing y on every y_valid until NUM_SAMPLES are taken
//   DONE  | run complete; sig/count frozen until the next start
module y_signature_misr #(
  parameter int                 Y_W         = 646,
  parameter int                 SIG_W       = 32,
  parameter int                 NUM_SAMPLES = 21,
  parameter logic [SIG_W-1:0]   POLY        = 32'h04C11DB7,
  parameter logic [SIG_W-1:0]   SEED        = 32'hFFFFFFFF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               y_valid,
  input  logic [Y_W-1:0]     y,
`ifdef SIG_COMPARE_EN
  input  logic [SIG_W-1:0]   exp_sig,
`endif
  output logic               busy,
  output logic               done,
  output logic [SIG_W-1:0]   sig,
  output logic [4:0]         count,
  output logic               match
);

  localparam int         NCHUNK = (Y_W + SIG_W - 1) / SIG_W;
  localparam int         PAD_W  = NCHUNK * SIG_W;
  localparam logic [4:0] LAST   = 5'(NUM_SAMPLES);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [SIG_W-1:0]  sig_q, sig_d;
  logic [4:0]        count_q, count_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic [PAD_W-1:0]  y_pad;
  logic [SIG_W-1:0]  fold;
  logic [SIG_W-1:0]  misr_next;
  logic [4:0]        count_inc;

  // Zero-extend so the top chunk carries only the leftover y bits.
  assign y_pad = PAD_W'(y);

  always_comb begin
    fold = '0;
    for (int i = 0; i < NCHUNK; i++) begin
      fold = fold ^ y_pad[i*SIG_W +: SIG_W];
    end
  end

  assign misr_next = {sig_q[SIG_W-2:0], 1'b0}
                   ^ (sig_q[SIG_W-1] ? POLY : '0)
                   ^ fold;

  // Cannot wrap: RUN is left as soon as count reaches LAST (<= 31).
  assign count_inc = count_q + 5'd1;

  always_comb begin
    state_d = state_q;
    sig_d   = sig_q;
    count_d = count_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        // A y_valid on the accepting edge is deliberately dropped.
        if (start) begin
          sig_d   = SEED;
          count_d = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (y_valid) begin
          sig_d   = misr_next;
          count_d = count_inc;
          if (count_inc == LAST) begin
            state_d = S_DONE;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        sig_d   = SEED;
        count_d = '0;
      end
    endcase
    busy_d = (state_d == S_RUN);
    done_d = (state_d == S_DONE);
  end

`ifdef SIG_COMPARE_EN
  logic match_q, match_d;

  // Evaluated on the next-state value so match is already valid on the
  // cycle done first reads high.
  always_comb begin
    match_d = (state_d == S_DONE) && (sig_d == exp_sig);
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      sig_q   <= SEED;
      count_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef SIG_COMPARE_EN
      match_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      sig_q   <= sig_d;
      count_q <= count_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef SIG_COMPARE_EN
      match_q <= match_d;
`endif
    end
  end

  assign busy  = busy_q;
  assign done  = done_q;
  assign sig   = sig_q;
  assign count = count_q;
`ifdef SIG_COMPARE_EN
  assign match = match_q;
`else
  assign match = 1'b0;
`endif

endmodule
